param_fifo: RTL and testbench

- Parametrised synchronous FIFO replacing the fixed 6-bit FIFO used between the PPU/CPU-side producers and consumers.
- Adds configurable width and depth, an optional first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Single clock domain.

---
 rtl/param_fifo.sv | 95 +++++++++
 tb/tb_param_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with optional first-word-fall-through
// read, programmable almost-full/almost-empty levels, an occupancy count and
// sticky overflow/underflow flags. Full/empty come only from count.
module param_fifo #(
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     WE,
  input  logic                     RE,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             write_ok, read_ok;

  // Acceptance is judged on the pre-edge occupancy.
  assign write_ok = WE & ~full;
  assign read_ok  = RE & ~empty;

  // Status decoded straight from the registered count.
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // Storage is never cleared; a write held off by reset does not land.
  always_ff @(posedge clk) begin
    if (reset && write_ok) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_ok) wr_ptr <= wr_ptr + AW'(1);
      if (read_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({write_ok, read_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (WE && full)   overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      if (RE && empty)  underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; zero while nothing is stored.
      always_comb begin
        data_out = '0;
        if (!empty) data_out = mem[rd_ptr];
      end
    end else begin : g_std
      // Registered read: popped word appears after the read edge, else holds.
      always_ff @(posedge clk) begin
        if (!reset)       data_out <= '0;
        else if (read_ok) data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: queue-based reference model with a scoreboard for the
// default (registered-read) configuration, plus directed checks of a small
// FWFT instance.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset, WE, RE, clr_err;
  logic [5:0] data_in, data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  logic       f_rst, f_we, f_re, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [2:0] f_count;

  int ncmp = 0;
  int nerr = 0;
  bit mon_en = 0;

  int mq[$];      // model contents, head at index 0
  int sb[$];      // words expected on data_out after a read edge
  int m_dout = 0;
  bit m_ovf = 0, m_udf = 0;

  always #5 clk = ~clk;

  param_fifo dut (
    .clk(clk), .reset(reset), .WE(WE), .RE(RE), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) dutf (
    .clk(clk), .reset(f_rst), .WE(f_we), .RE(f_re), .data_in(f_din),
    .clr_err(f_clr), .data_out(f_dout), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus for the main instance; model advances on the edge.
  task automatic cyc(input bit we, input bit re, input bit clr, input bit rs, input int d);
    bit wok, rok;
    WE = we; RE = re; clr_err = clr; reset = rs; data_in = d[5:0];
    @(posedge clk);
    if (!rs) begin
      mq.delete(); m_dout = 0; m_ovf = 0; m_udf = 0;
    end else begin
      wok = we && (mq.size() < 16);
      rok = re && (mq.size() > 0);
      m_ovf = (we && !wok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (re && mq.size() == 0) ? 1'b1 : (clr ? 1'b0 : m_udf);
      if (rok) begin
        m_dout = mq.pop_front();
        sb.push_back(m_dout);
      end
      if (wok) mq.push_back(d & 6'h3f);
    end
    #1;
  endtask

  // Monitor: pop the scoreboard whenever a read edge produced a word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) chk("rd_data", data_out, sb.pop_front());
      else               chk("dout_hold", data_out, m_dout);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 16);
      chk("almost_empty", almost_empty, mq.size() <= 2);
      chk("almost_full", almost_full, mq.size() >= 14);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
    end
  end

  initial begin
    int fill[16] = '{'h20, 'h02, 'h34, 'h0F, 'h0F, 'h10, 'h11, 'h12,
                     'h13, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19, 'h1A};
    f_rst = 0; f_we = 0; f_re = 0; f_clr = 0; f_din = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    f_rst = 1;
    mon_en = 1;

    // Random traffic, then reset held for two edges.
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1), 0, 1, $urandom_range(0, 63));
    cyc($urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 5);
    cyc(1, 1, 1, 0, 7);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);

    // Fill, then one write too many.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, fill[i]);
    chk("fill_full", full, 1);
    cyc(1, 0, 0, 1, 'h17);
    chk("ovf_17th", overflow, 1);
    chk("count_17th", count, 16);

    // Drain, then one read too many, then clear the errors.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, 0);
    chk("drain_empty", empty, 1);
    cyc(0, 1, 0, 1, 0);
    chk("udf_dout", data_out, 'h1A);
    chk("udf_set", underflow, 1);
    cyc(0, 0, 1, 1, 0);
    chk("clr_ovf", overflow, 0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, $urandom_range(0, 63));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, i);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1, 0);
    chk("wrap_last", data_out, 'h0B);

    // Concurrent traffic at a steady occupancy of 5.
    for (int i = 0; i < 5; i++)  cyc(1, 0, 0, 1, $urandom_range(0, 63));
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 1, $urandom_range(0, 63));
    chk("conc_count", count, 5);
    for (int i = 0; i < 5; i++)  cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 'h2A);
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_udf", underflow, 1);
    cyc(0, 0, 1, 1, 0);

    // Long random run biased toward both ends, with sporadic clears/resets.
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 50) % 2;
      cyc($urandom_range(0, 3) >= bias + 1, $urandom_range(0, 3) >= 2 - bias,
          $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0, $urandom_range(0, 63));
    end

    // FWFT instance, directed.
    f_we = 1; f_din = 8'h15; cyc(0, 0, 0, 1, 0); f_we = 0;
    chk("fwft_first", f_dout, 8'h15);
    chk("fwft_nempty", f_empty, 0);
    chk("fwft_ae", f_ae, 1);
    f_we = 1; f_din = 8'hA3; cyc(0, 0, 0, 1, 0); f_we = 0;
    chk("fwft_head", f_dout, 8'h15);
    f_re = 1; cyc(0, 0, 0, 1, 0);
    chk("fwft_pop1", f_dout, 8'hA3);
    chk("fwft_cnt1", f_count, 1);
    cyc(0, 0, 0, 1, 0); f_re = 0;
    chk("fwft_pop2", f_dout, 0);
    chk("fwft_empty", f_empty, 1);
    f_re = 1; cyc(0, 0, 0, 1, 0); f_re = 0;
    chk("fwft_udf", f_udf, 1);
    for (int i = 1; i <= 5; i++) begin
      f_we = 1; f_din = 8'(i * 17); cyc(0, 0, 0, 1, 0);
    end
    f_we = 0;
    chk("fwft_full", f_full, 1);
    chk("fwft_af", f_af, 1);
    chk("fwft_ovf", f_ovf, 1);
    chk("fwft_cnt4", f_count, 4);
    chk("fwft_head4", f_dout, 8'd17);
    f_we = 1; f_re = 1; f_din = 8'h99; cyc(0, 0, 0, 1, 0); f_we = 0; f_re = 0;
    chk("fwft_full_wr_rd_cnt", f_count, 3);
    chk("fwft_full_wr_rd_dout", f_dout, 8'd34);
    f_clr = 1; cyc(0, 0, 0, 1, 0); f_clr = 0;
    chk("fwft_clr_ovf", f_ovf, 0);
    chk("fwft_clr_udf", f_udf, 0);

    cyc(0, 0, 0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
